// File: rtl/rpn_stack_calc.sv
// RPN evaluator: pushes parsed operands onto a LIFO stack and applies ADD/SUB/MUL/PEEK to the top two entries.
// Latency: a push lands on the edge it is accepted; an op writes back 3 edges after acceptance (IDLE->READ->EXEC->WRITE).
// Backpressure: there is no stall output; a 1-entry pending slot absorbs one strobe while busy, and further strobes are dropped with err_overrun.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   num_in / num_valid       operand push strobe from the digit parser
//   op / op_valid            operator strobe (00 ADD, 01 SUB, 10 MUL, 11 PEEK)
//   clear                    flush stack, pending slot and error flags (result kept)
//   result / result_valid    last completed op value, with a 1-cycle update pulse
//   top / depth              current stack top (0 when empty) and occupancy
//   busy                     op in flight
//   err_underflow/overflow/overrun   sticky error flags
module rpn_stack_calc #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           num_in,
    input  logic                       num_valid,
    input  logic [1:0]                 op,
    input  logic                       op_valid,
    input  logic                       clear,
    output logic [WIDTH-1:0]           result,
    output logic                       result_valid,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       busy,
    output logic                       err_underflow,
    output logic                       err_overflow,
    output logic                       err_overrun
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] stack_mem [DEPTH];
    logic [DW-1:0]    depth_q;
    logic [AW-1:0]    idx_top, idx_below, idx_push;

    // Pending slot: one buffered strobe, either an operand or an operator.
    logic             pend_vld;
    logic             pend_is_op;
    logic [WIDTH-1:0] pend_dat;
    logic [1:0]       pend_op;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [WIDTH-1:0] result_q;
    logic             result_vld_q;
    logic             err_uf_q, err_of_q, err_or_q;

    // Decoded actions for this cycle.
    logic             push_req, push_ok;
    logic [WIDTH-1:0] push_dat;
    logic             start_op;
    logic [1:0]       start_code;
    logic             slot_load, slot_is_op, slot_take;
    logic             overrun;
    logic             underflow;

    // Entry indices: depth-1 is the top, depth-2 the operand below it.
    assign idx_top   = AW'(depth_q - DW'(1));
    assign idx_below = AW'(depth_q - DW'(2));
    assign idx_push  = AW'(depth_q);

    // Stack content cannot change while busy (pushes are parked in the slot),
    // so checking the operand count in READ is the same as checking at accept.
    assign underflow = (op_q == OP_PEEK) ? (depth_q < DW'(1)) : (depth_q < DW'(2));
    assign push_ok   = push_req && (depth_q != DW'(DEPTH));

    always_comb begin
        state_d    = state_q;
        push_req   = 1'b0;
        push_dat   = num_in;
        start_op   = 1'b0;
        start_code = op;
        slot_load  = 1'b0;
        slot_is_op = 1'b0;
        slot_take  = 1'b0;
        overrun    = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            if (pend_vld) begin
                // Drain the parked strobe first; the freed slot takes one new strobe.
                slot_take = 1'b1;
                if (pend_is_op) begin
                    start_op   = 1'b1;
                    start_code = pend_op;
                end else begin
                    push_req = 1'b1;
                    push_dat = pend_dat;
                end
                if (num_valid) begin
                    slot_load = 1'b1;
                    overrun   = op_valid;
                end else if (op_valid) begin
                    slot_load  = 1'b1;
                    slot_is_op = 1'b1;
                end
            end else if (num_valid) begin
                // Simultaneous op is parked behind the operand.
                push_req = 1'b1;
                if (op_valid) begin
                    slot_load  = 1'b1;
                    slot_is_op = 1'b1;
                end
            end else if (op_valid) begin
                start_op = 1'b1;
            end
            if (start_op) begin
                state_d = S_READ;
            end
        end else begin
            if (num_valid) begin
                if (!pend_vld) begin
                    slot_load = 1'b1;
                end else begin
                    overrun = 1'b1;
                end
            end
            if (op_valid) begin
                if (!pend_vld && !num_valid) begin
                    slot_load  = 1'b1;
                    slot_is_op = 1'b1;
                end else begin
                    overrun = 1'b1;
                end
            end
            case (state_q)
                S_READ:  state_d = underflow ? S_IDLE : S_EXEC;
                S_EXEC:  state_d = S_WRITE;
                S_WRITE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q      <= '0;
            pend_vld     <= 1'b0;
            pend_is_op   <= 1'b0;
            pend_dat     <= '0;
            pend_op      <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            result_q     <= '0;
            result_vld_q <= 1'b0;
            err_uf_q     <= 1'b0;
            err_of_q     <= 1'b0;
            err_or_q     <= 1'b0;
        end else begin
            result_vld_q <= 1'b0;
            if (clear) begin
                depth_q  <= '0;
                pend_vld <= 1'b0;
                err_uf_q <= 1'b0;
                err_of_q <= 1'b0;
                err_or_q <= 1'b0;
            end else begin
                if (push_req) begin
                    if (push_ok) begin
                        depth_q <= depth_q + DW'(1);
                    end else begin
                        err_of_q <= 1'b1;
                    end
                end
                if (start_op) begin
                    op_q <= start_code;
                end
                if (slot_load) begin
                    pend_vld   <= 1'b1;
                    pend_is_op <= slot_is_op;
                    pend_dat   <= num_in;
                    pend_op    <= op;
                end else if (slot_take) begin
                    pend_vld <= 1'b0;
                end
                if (overrun) begin
                    err_or_q <= 1'b1;
                end
                case (state_q)
                    S_READ: begin
                        if (underflow) begin
                            err_uf_q <= 1'b1;
                        end else begin
                            b_q <= stack_mem[idx_top];
                            a_q <= stack_mem[idx_below];
                        end
                    end
                    S_EXEC: begin
                        case (op_q)
                            OP_ADD:  res_q <= a_q + b_q;
                            OP_SUB:  res_q <= a_q - b_q;
                            OP_MUL:  res_q <= a_q * b_q;
                            default: res_q <= b_q;
                        endcase
                    end
                    S_WRITE: begin
                        result_q     <= res_q;
                        result_vld_q <= 1'b1;
                        if (op_q != OP_PEEK) begin
                            depth_q <= depth_q - DW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stack RAM carries no reset; entries at or above depth are never read.
    always_ff @(posedge clk) begin
        if (!rst && !clear) begin
            if (push_ok) begin
                stack_mem[idx_push] <= push_dat;
            end
            if (state_q == S_WRITE && op_q != OP_PEEK) begin
                stack_mem[idx_below] <= res_q;
            end
        end
    end

    assign result        = result_q;
    assign result_valid  = result_vld_q;
    assign top           = (depth_q == '0) ? '0 : stack_mem[idx_top];
    assign depth         = depth_q;
    assign busy          = (state_q != S_IDLE);
    assign err_underflow = err_uf_q;
    assign err_overflow  = err_of_q;
    assign err_overrun   = err_or_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Bench for rpn_stack_calc: directed scenarios followed by random push/op/clear
// traffic, all checked against a queue-based model of the operand stack.
module tb_rpn_stack_calc;

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] MUL  = 2'b10;
    localparam logic [1:0] PEEK = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] num_in;
    logic        num_valid;
    logic [1:0]  op;
    logic        op_valid;
    logic        clear;
    logic [15:0] result;
    logic        result_valid;
    logic [15:0] top;
    logic [3:0]  depth;
    logic        busy;
    logic        err_underflow;
    logic        err_overflow;
    logic        err_overrun;

    always #5 clk = ~clk;

    rpn_stack_calc #(.WIDTH(16), .DEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .num_in        (num_in),
        .num_valid     (num_valid),
        .op            (op),
        .op_valid      (op_valid),
        .clear         (clear),
        .result        (result),
        .result_valid  (result_valid),
        .top           (top),
        .depth         (depth),
        .busy          (busy),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow),
        .err_overrun   (err_overrun)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model
    logic [15:0] stk[$];
    logic [15:0] m_result;
    bit          m_uf, m_of, m_or;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    endtask

    function automatic logic [15:0] m_top();
        return (stk.size() == 0) ? 16'h0000 : stk[stk.size()-1];
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_depth"}, depth, stk.size());
        chk({tag, "_top"}, top, m_top());
        chk({tag, "_err_uf"}, err_underflow, m_uf);
        chk({tag, "_err_of"}, err_overflow, m_of);
        chk({tag, "_err_or"}, err_overrun, m_or);
    endtask

    task automatic push(input logic [15:0] v);
        @(negedge clk);
        num_in = v;
        num_valid = 1'b1;
        @(posedge clk);
        #1;
        num_valid = 1'b0;
        if (stk.size() == 8) m_of = 1'b1;
        else stk.push_back(v);
        chk("push_rv", result_valid, 0);
        check_state("push");
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        stk.delete();
        m_uf = 1'b0;
        m_of = 1'b0;
        m_or = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_rv", result_valid, 0);
        chk("clr_result_kept", result, m_result);
        check_state("clr");
    endtask

    task automatic run_op(input logic [1:0] o);
        int          need;
        logic [15:0] a, b, r;
        longint      prod;
        need = (o == PEEK) ? 1 : 2;
        @(negedge clk);
        op = o;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        chk("op_busy", busy, 1);
        if (stk.size() < need) begin
            @(posedge clk);
            #1;
            m_uf = 1'b1;
            chk("uf_busy", busy, 0);
            chk("uf_rv", result_valid, 0);
            check_state("uf");
        end else begin
            b = stk[stk.size()-1];
            a = (o == PEEK) ? 16'h0 : stk[stk.size()-2];
            case (o)
                ADD:  r = 16'((int'(a) + int'(b)) % 65536);
                SUB:  r = 16'((int'(a) + 65536 - int'(b)) % 65536);
                MUL:  begin
                    prod = longint'(a) * longint'(b);
                    r = 16'(prod % 65536);
                end
                default: r = b;
            endcase
            if (o != PEEK) begin
                void'(stk.pop_back());
                void'(stk.pop_back());
                stk.push_back(r);
            end
            repeat (2) begin
                @(posedge clk);
                #1;
                chk("op_wait_rv", result_valid, 0);
                chk("op_wait_busy", busy, 1);
            end
            @(posedge clk);
            #1;
            m_result = r;
            chk("op_rv", result_valid, 1);
            chk("op_result", result, r);
            chk("op_done_busy", busy, 0);
            check_state("op");
            @(posedge clk);
            #1;
            chk("op_rv_pulse", result_valid, 0);
        end
    endtask

    task automatic strobe_op(input logic [1:0] o);
        @(negedge clk);
        op = o;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic strobe_num(input logic [15:0] v);
        @(negedge clk);
        num_in = v;
        num_valid = 1'b1;
        @(posedge clk);
        #1;
        num_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        num_in = '0;
        num_valid = 1'b0;
        op = '0;
        op_valid = 1'b0;
        clear = 1'b0;
        m_result = '0;
        m_uf = 1'b0;
        m_of = 1'b0;
        m_or = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_busy", busy, 0);
        check_state("rst");
        @(negedge clk);
        rst = 1'b0;

        // Basic arithmetic
        push(16'd3); push(16'd4); run_op(ADD);
        chk("add_7", result, 16'd7);
        do_clear();
        push(16'd10); push(16'd3); run_op(SUB);
        chk("sub_7", result, 16'd7);
        do_clear();
        push(16'd3); push(16'd10); run_op(SUB);
        chk("sub_wrap", result, 16'hFFF9);
        do_clear();
        push(16'd300); push(16'd300); run_op(MUL);
        chk("mul_low", result, 16'd24464);
        run_op(PEEK);
        chk("peek_val", result, 16'd24464);
        chk("peek_depth", depth, 1);

        // Underflow then clear
        do_clear();
        push(16'd5); run_op(ADD);
        chk("uf_flag", err_underflow, 1);
        do_clear();
        chk("uf_cleared", err_underflow, 0);

        // Overflow
        for (int i = 1; i <= 9; i++) push(16'(i));
        chk("of_depth", depth, 8);
        chk("of_top", top, 8);
        chk("of_flag", err_overflow, 1);
        do_clear();

        // Push while busy is parked and applied after writeback
        push(16'd2); push(16'd3);
        strobe_op(ADD);
        strobe_num(16'd6);
        chk("park_busy", busy, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("park_rv", result_valid, 1);
        chk("park_result", result, 5);
        chk("park_depth_wb", depth, 1);
        @(posedge clk); #1;
        chk("park_depth", depth, 2);
        chk("park_top", top, 6);
        chk("park_no_or", err_overrun, 0);
        m_result = 16'd5;
        do_clear();

        // Two strobes while busy: second is lost
        push(16'd2); push(16'd3);
        strobe_op(ADD);
        strobe_num(16'd1);
        strobe_num(16'd2);
        chk("ovr_flag", err_overrun, 1);
        @(posedge clk); #1;
        chk("ovr_result", result, 5);
        @(posedge clk); #1;
        chk("ovr_depth", depth, 2);
        chk("ovr_top", top, 1);
        do_clear();

        // Clear aborts an in-flight op
        push(16'd2); push(16'd3);
        strobe_op(ADD);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        stk.delete();
        chk("abort_busy", busy, 0);
        chk("abort_depth", depth, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_rv", result_valid, 0);
            chk("abort_depth_hold", depth, 0);
        end
        chk("abort_result_kept", result, m_result);

        // Same-cycle num and op: num pushed, op runs from the slot
        push(16'd4);
        @(negedge clk);
        num_in = 16'd9;
        num_valid = 1'b1;
        op = SUB;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        num_valid = 1'b0;
        op_valid = 1'b0;
        chk("both_depth", depth, 2);
        chk("both_top", top, 9);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("both_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        chk("both_rv", result_valid, 1);
        chk("both_result", result, 16'hFFFB);
        chk("both_depth_wb", depth, 1);
        m_result = 16'hFFFB;
        do_clear();

        // Random traffic against the model
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 9) begin
                if ($urandom_range(0, 1) == 1) push(16'($urandom));
                else push(16'($urandom_range(0, 20)));
            end else if (r < 18) begin
                run_op(2'($urandom_range(0, 3)));
            end else begin
                do_clear();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
